itype_issue_ctrl: RTL
=====================

Name: itype_issue_ctrl

Overview:
- Issue controller that sequences RV32I I-type ALU instructions (opcode 0010011) through the shared ALU datapath and register file.
- Buffers incoming instructions in a small FIFO and decodes each one.
- Runs a read / execute / writeback sequence per instruction and flags illegal encodings.
- Sits between the instruction source and the combinational I-type ALU / synchronous-read register file.

Parameters:
DEPTH, 4, instruction FIFO entries (power of two, >=2)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
instr_valid  input  1  instruction offered
instr  input  32  instruction word
instr_ready  output  1  FIFO can accept (= !full, 0 while rst low)
rf_raddr  output  5  register file read address (rs1)
rf_rdata  input  32  register file read data, valid one cycle after rf_raddr
alu_op  output  4  ALU operation select
alu_a  output  32  ALU operand A
alu_imm  output  32  ALU immediate operand
alu_result  input  32  combinational ALU result
rf_we  output  1  register file write enable
rf_waddr  output  5  write address (rd)
rf_wdata  output  32  write data
illegal  output  1  one-cycle pulse, illegal instruction dropped
busy  output  1  state != IDLE or FIFO non-empty
retired_count  output  CNT_W  legal instructions completed

Behaviour:
- Reset (rst=0, async): FIFO empty, state IDLE, all outputs 0, retired_count 0. Mid-operation reset drops the in-flight instruction and all FIFO contents; rf_we is never asserted for dropped work.
- FIFO push on instr_valid && instr_ready. instr_ready depends only on !full; a pop in the same cycle does not raise it. No bypass: a word pushed into an empty FIFO is poppable the next cycle.
- FSM states: IDLE, RD, EX, WB.
- IDLE: if FIFO non-empty, pop into instr_reg and go to RD.
- RD: rf_raddr = rs1 (instr[19:15]).
  - Legal instruction: go to EX.
  - Illegal instruction: illegal=1 this cycle, go to IDLE, no write, no count.
- EX: alu_a = rf_rdata, alu_imm, alu_op driven; alu_result registered into the wdata register at end of cycle; go to WB.
- WB: rf_waddr = rd, rf_wdata = registered result, rf_we = 1 unless rd == 0. retired_count += 1, wrapping to 0 at all-ones. If FIFO non-empty, pop and go to RD; else go to IDLE.
- Outside EX: alu_op, alu_a, alu_imm = 0. Outside WB: rf_we, rf_waddr, rf_wdata = 0. Outside RD: rf_raddr = 0.
- Latency: pop-from-IDLE cycle N → RD N+1 → EX N+2 → rf_we N+3. Steady-state throughput is one instruction per 3 cycles.
- No forwarding is needed: the WB write completes before the next RD address is presented.
- alu_op encoding:
  - ADDI 0000, SLLI 0001, SLTI 0010, SLTIU 0011, XORI 0100
  - SRLI 0101, SRAI 1101, ORI 0110, ANDI 0111
- alu_imm:
  - Shifts: zero-extended shamt instr[24:20].
  - All others: sign-extended instr[31:20].
- Illegal when any of:
  - opcode != 0010011
  - funct3 = 001 and instr[31:25] != 0000000
  - funct3 = 101 and instr[31:25] not in {0000000, 0100000}

Test Plan:
- ADDI 32'b0011000_00100_00111_000_01001_0010011, rf_rdata=5, alu_result=0x309 → rf_raddr=7 in RD; alu_op=0000, alu_a=5, alu_imm=0x304 in EX; rf_we=1, rf_waddr=9, rf_wdata=0x309 three cycles after pop; retired_count=1.
- SRAI 32'b0100000_00011_00101_101_01101_0010011 → alu_op=1101, alu_imm=3, rf_waddr=13. Same word with funct7=0000001 → illegal pulse in RD, no rf_we, retired_count unchanged.
- 32'h1234_5678 (bad opcode) → illegal=1 for exactly one cycle, FSM back to IDLE, rf_we stays 0.
- ADDI with rd=0 (32'h0010_0013) → rf_we stays 0 through WB, retired_count increments by 1.
- Six back-to-back pushes with instr_valid held, DEPTH=4 → instr_ready falls on cycle 6, refills after the next WB pop; all six retire in order with rf_we pulses 3 cycles apart; retired_count=6.
- Assert rst=0 during EX of the second of three queued instructions → outputs 0 immediately, FIFO empty, no further rf_we after release, retired_count=0.

Source files
------------

// File: rtl/itype_issue_ctrl.sv
// rtl/itype_issue_ctrl.sv - RV32I I-type ALU issue controller with instruction FIFO
//
// Buffers I-type instructions and sequences each one through read (rs1 address),
// execute (ALU operands) and writeback (rd write), flagging illegal encodings.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   instr_valid/instr   instruction offer; instr_ready = FIFO not full
//   rf_raddr/rf_rdata   register file read port (data one cycle after address)
//   alu_op/alu_a/alu_imm/alu_result  combinational ALU interface
//   rf_we/rf_waddr/rf_wdata          register file write port
//   illegal             one-cycle pulse when an illegal instruction is dropped
//   busy                work in flight or queued
//   retired_count       legal instructions completed (wraps)

module itype_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    output logic [4:0]       rf_raddr,
    input  logic [31:0]      rf_rdata,
    output logic [3:0]       alu_op,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_imm,
    input  logic [31:0]      alu_result,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             illegal,
    output logic             busy,
    output logic [CNT_W-1:0] retired_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_EX,
        S_WB
    } state_t;

    logic [31:0]      fifo_mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    state_t           state_q;
    logic [31:0]      instr_q;
    logic [31:0]      wdata_q;
    logic [CNT_W-1:0] retired_q;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rd;
    logic       is_shift;
    logic       illegal_dec;

    assign fifo_full  = (count_q == (AW+1)'(DEPTH));
    assign fifo_empty = (count_q == '0);

    // Ready is held low while reset is asserted even though the FIFO is empty.
    assign instr_ready = rst && !fifo_full;
    assign push        = instr_valid && instr_ready;
    // The FSM pops only when it is about to start a new instruction.
    assign pop         = !fifo_empty && (state_q == S_IDLE || state_q == S_WB);

    assign opcode   = instr_q[6:0];
    assign rd       = instr_q[11:7];
    assign funct3   = instr_q[14:12];
    assign rs1      = instr_q[19:15];
    assign funct7   = instr_q[31:25];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        illegal_dec = 1'b0;
        if (opcode != OPC_ITYPE) begin
            illegal_dec = 1'b1;
        end else if (funct3 == 3'b001 && funct7 != 7'b0000000) begin
            illegal_dec = 1'b1;
        end else if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
            illegal_dec = 1'b1;
        end
    end

    // Storage has no reset: contents are only observable through valid pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= instr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            instr_q   <= '0;
            wdata_q   <= '0;
            retired_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase

            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        instr_q <= fifo_mem_q[rd_ptr_q];
                        state_q <= S_RD;
                    end
                end
                S_RD: begin
                    state_q <= illegal_dec ? S_IDLE : S_EX;
                end
                S_EX: begin
                    wdata_q <= alu_result;
                    state_q <= S_WB;
                end
                S_WB: begin
                    retired_q <= retired_q + CNT_W'(1);
                    if (pop) begin
                        instr_q <= fifo_mem_q[rd_ptr_q];
                        state_q <= S_RD;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rf_raddr = '0;
        alu_op   = '0;
        alu_a    = '0;
        alu_imm  = '0;
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        illegal  = 1'b0;
        case (state_q)
            S_RD: begin
                rf_raddr = rs1;
                illegal  = illegal_dec;
            end
            S_EX: begin
                // Bit 3 distinguishes SRAI from SRLI via instr[30].
                alu_op  = {(funct3 == 3'b101) && instr_q[30], funct3};
                alu_a   = rf_rdata;
                alu_imm = is_shift ? {27'b0, instr_q[24:20]}
                                   : {{20{instr_q[31]}}, instr_q[31:20]};
            end
            S_WB: begin
                rf_we    = (rd != 5'd0);
                rf_waddr = rd;
                rf_wdata = wdata_q;
            end
            default: ;
        endcase
    end

    assign busy          = (state_q != S_IDLE) || !fifo_empty;
    assign retired_count = retired_q;

endmodule
